// File: rtl/ps_queue_fetch_wavepool_pkg.sv
// Shared issue/global definitions for the fetch-to-wavepool instruction queue.
package ps_queue_fetch_wavepool_pkg;

   localparam int unsigned WFID_W_DEF  = 6;
   localparam int unsigned PC_W_DEF    = 32;
   localparam int unsigned INSTR_W_DEF = 32;

endpackage

// File: rtl/ps_queue_ram.sv
// Queue payload storage: one synchronous write port, one asynchronous read port.
module ps_queue_ram #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ps_queue_fetch_wavepool.sv
// Fetch-return to wavepool instruction queue (circular FIFO with per-entry live bits).
// Define PS_QUEUE_WF_FLUSH_EN to enable per-wavefront flush; otherwise flush ports are ignored.
module ps_queue_fetch_wavepool
   import ps_queue_fetch_wavepool_pkg::*;
#(
   parameter int unsigned WFID_W  = WFID_W_DEF,
   parameter int unsigned PC_W    = PC_W_DEF,
   parameter int unsigned INSTR_W = INSTR_W_DEF,
   parameter int unsigned DEPTH   = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic                       in_first,
   input  logic [WFID_W-1:0]          in_wfid,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [INSTR_W-1:0]         in_instr,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic                       out_first,
   output logic [WFID_W-1:0]          out_wfid,
   output logic [INSTR_W+PC_W-1:0]    out_instr_pc,
   input  logic                       out_ready,
   input  logic                       flush_valid,
   input  logic [WFID_W-1:0]          flush_wfid,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW  = $clog2(DEPTH);
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned PLW = 1 + WFID_W + INSTR_W + PC_W;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] live_q, live_d;
   logic             in_ready_q, in_ready_d;
   logic             push, pop, head_occ, head_live, head_show;
   logic [PLW-1:0]   rd_data;

`ifdef PS_QUEUE_WF_FLUSH_EN
   // Shadow copy of each slot's wfid so all slots can be matched in parallel.
   logic [WFID_W-1:0] wfid_tag_q [DEPTH];

   always_ff @(posedge clk) begin
      if (push) begin
         wfid_tag_q[wr_ptr_q] <= in_wfid;
      end
   end
`else
   logic unused_flush;
   assign unused_flush = ^{flush_valid, flush_wfid};
`endif

   assign head_occ  = (count_q != '0);
   assign head_live = live_q[rd_ptr_q];
   assign head_show = head_occ & head_live;
   assign push      = in_valid & in_ready_q;
   // Killed heads drain on their own, one per cycle, without out_valid.
   assign pop       = head_occ & (~head_live | out_ready);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      live_d   = live_q;
`ifdef PS_QUEUE_WF_FLUSH_EN
      if (flush_valid) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (wfid_tag_q[AW'(i)] == flush_wfid) begin
               live_d[AW'(i)] = 1'b0;
            end
         end
      end
`endif
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
`ifdef PS_QUEUE_WF_FLUSH_EN
         live_d[wr_ptr_q] = ~(flush_valid && (in_wfid == flush_wfid));
`else
         live_d[wr_ptr_q] = 1'b1;
`endif
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      in_ready_d = (count_d < FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         live_q     <= '0;
         in_ready_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         live_q     <= live_d;
         in_ready_q <= in_ready_d;
      end
   end

   ps_queue_ram #(
      .DEPTH (DEPTH),
      .WIDTH (PLW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i ({in_first, in_wfid, in_instr, in_pc}),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_data)
   );

   assign in_ready     = in_ready_q;
   assign count        = count_q;
   assign out_valid    = head_show;
   assign out_first    = head_show & rd_data[PLW-1];
   assign out_wfid     = head_show ? rd_data[PLW-2 -: WFID_W] : '0;
   assign out_instr_pc = head_show ? rd_data[INSTR_W+PC_W-1:0] : '0;

endmodule

// File: tb/tb_ps_queue_fetch_wavepool.sv
// Self-checking bench: DEPTH=2 vector table, wavefront flush sequence and a random run on DEPTH=4 against a queue model.
module tb_ps_queue_fetch_wavepool;

`ifdef PS_QUEUE_WF_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DUT A: DEPTH=2
   logic        rst_a, iv_a, if_a, ordy_a, fv_a;
   logic [5:0]  iw_a, fw_a;
   logic [31:0] ipc_a, iins_a;
   logic        rdy_a, ov_a, of_a;
   logic [5:0]  ow_a;
   logic [63:0] oip_a;
   logic [1:0]  cnt_a;

   // DUT B: DEPTH=4
   logic        rst_b, iv_b, if_b, ordy_b, fv_b;
   logic [5:0]  iw_b, fw_b;
   logic [31:0] ipc_b, iins_b;
   logic        rdy_b, ov_b, of_b;
   logic [5:0]  ow_b;
   logic [63:0] oip_b;
   logic [2:0]  cnt_b;

   ps_queue_fetch_wavepool #(.WFID_W(6), .PC_W(32), .INSTR_W(32), .DEPTH(2)) dut_a (
      .clk(clk), .rst(rst_a), .in_valid(iv_a), .in_first(if_a), .in_wfid(iw_a),
      .in_pc(ipc_a), .in_instr(iins_a), .in_ready(rdy_a), .out_valid(ov_a),
      .out_first(of_a), .out_wfid(ow_a), .out_instr_pc(oip_a), .out_ready(ordy_a),
      .flush_valid(fv_a), .flush_wfid(fw_a), .count(cnt_a)
   );

   ps_queue_fetch_wavepool #(.WFID_W(6), .PC_W(32), .INSTR_W(32), .DEPTH(4)) dut_b (
      .clk(clk), .rst(rst_b), .in_valid(iv_b), .in_first(if_b), .in_wfid(iw_b),
      .in_pc(ipc_b), .in_instr(iins_b), .in_ready(rdy_b), .out_valid(ov_b),
      .out_first(of_b), .out_wfid(ow_b), .out_instr_pc(oip_b), .out_ready(ordy_b),
      .flush_valid(fv_b), .flush_wfid(fw_b), .count(cnt_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic        iv;
      logic        first;
      logic [5:0]  wfid;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        ordy;
      logic        e_rdy;
      logic        e_ov;
      logic        e_first;
      logic [5:0]  e_wfid;
      logic [1:0]  e_cnt;
      logic [63:0] e_ip;
   } vec_t;

   typedef struct {
      logic        first;
      logic [5:0]  wfid;
      logic [31:0] pc;
      logic [31:0] instr;
      bit          live;
   } ent_t;

   vec_t tbl[18];
   ent_t mq[$];
   bit   m_rdy;
   logic [5:0] seen[$];
   logic [5:0] exp_seen[$];

   initial begin
      // row inputs: rst iv first wfid pc instr ordy | expected (state before the edge): rdy ov first wfid count instr_pc
      tbl[0]  = '{1'b1,1'b0,1'b0,6'd0,32'h0,32'h0,1'b0,        1'b0,1'b0,1'b0,6'd0,2'd0,64'h0};
      tbl[1]  = '{1'b0,1'b0,1'b0,6'd0,32'h0,32'h0,1'b0,        1'b0,1'b0,1'b0,6'd0,2'd0,64'h0};
      tbl[2]  = '{1'b0,1'b1,1'b1,6'd5,32'h100,32'hBF810000,1'b0, 1'b1,1'b0,1'b0,6'd0,2'd0,64'h0};
      tbl[3]  = '{1'b0,1'b1,1'b0,6'd1,32'h104,32'h11111111,1'b0, 1'b1,1'b1,1'b1,6'd5,2'd1,64'hBF810000_00000100};
      tbl[4]  = '{1'b0,1'b1,1'b0,6'd2,32'h108,32'h22222222,1'b0, 1'b0,1'b1,1'b1,6'd5,2'd2,64'hBF810000_00000100};
      tbl[5]  = '{1'b0,1'b0,1'b0,6'd0,32'h0,32'h0,1'b0,        1'b0,1'b1,1'b1,6'd5,2'd2,64'hBF810000_00000100};
      tbl[6]  = '{1'b0,1'b0,1'b0,6'd0,32'h0,32'h0,1'b1,        1'b0,1'b1,1'b1,6'd5,2'd2,64'hBF810000_00000100};
      tbl[7]  = '{1'b0,1'b0,1'b0,6'd0,32'h0,32'h0,1'b1,        1'b1,1'b1,1'b0,6'd1,2'd1,64'h11111111_00000104};
      tbl[8]  = '{1'b0,1'b0,1'b0,6'd0,32'h0,32'h0,1'b0,        1'b1,1'b0,1'b0,6'd0,2'd0,64'h0};
      tbl[9]  = '{1'b0,1'b1,1'b0,6'd4,32'h200,32'h44444444,1'b0, 1'b1,1'b0,1'b0,6'd0,2'd0,64'h0};
      tbl[10] = '{1'b0,1'b1,1'b0,6'd6,32'h204,32'h55555555,1'b0, 1'b1,1'b1,1'b0,6'd4,2'd1,64'h44444444_00000200};
      tbl[11] = '{1'b0,1'b1,1'b0,6'd7,32'h208,32'h66666666,1'b1, 1'b0,1'b1,1'b0,6'd4,2'd2,64'h44444444_00000200};
      tbl[12] = '{1'b0,1'b0,1'b0,6'd0,32'h0,32'h0,1'b0,        1'b1,1'b1,1'b0,6'd6,2'd1,64'h55555555_00000204};
      tbl[13] = '{1'b0,1'b1,1'b0,6'd9,32'h20C,32'h77777777,1'b0, 1'b1,1'b1,1'b0,6'd6,2'd1,64'h55555555_00000204};
      tbl[14] = '{1'b0,1'b0,1'b0,6'd0,32'h0,32'h0,1'b0,        1'b0,1'b1,1'b0,6'd6,2'd2,64'h55555555_00000204};
      tbl[15] = '{1'b1,1'b0,1'b0,6'd0,32'h0,32'h0,1'b1,        1'b0,1'b1,1'b0,6'd6,2'd2,64'h55555555_00000204};
      tbl[16] = '{1'b0,1'b0,1'b0,6'd0,32'h0,32'h0,1'b1,        1'b0,1'b0,1'b0,6'd0,2'd0,64'h0};
      tbl[17] = '{1'b0,1'b0,1'b0,6'd0,32'h0,32'h0,1'b1,        1'b1,1'b0,1'b0,6'd0,2'd0,64'h0};

      rst_a = 1'b1; iv_a = 1'b0; if_a = 1'b0; iw_a = '0; ipc_a = '0; iins_a = '0;
      ordy_a = 1'b0; fv_a = 1'b0; fw_a = '0;
      rst_b = 1'b1; iv_b = 1'b0; if_b = 1'b0; iw_b = '0; ipc_b = '0; iins_b = '0;
      ordy_b = 1'b0; fv_b = 1'b0; fw_b = '0;
      step();
      step();

      // Vector table on DUT A
      for (int i = 0; i < 18; i++) begin
         rst_a = tbl[i].rst; iv_a = tbl[i].iv; if_a = tbl[i].first; iw_a = tbl[i].wfid;
         ipc_a = tbl[i].pc; iins_a = tbl[i].instr; ordy_a = tbl[i].ordy;
         check($sformatf("v%0d_in_ready", i), 64'(rdy_a), 64'(tbl[i].e_rdy));
         check($sformatf("v%0d_out_valid", i), 64'(ov_a), 64'(tbl[i].e_ov));
         check($sformatf("v%0d_out_first", i), 64'(of_a), 64'(tbl[i].e_first));
         check($sformatf("v%0d_out_wfid", i), 64'(ow_a), 64'(tbl[i].e_wfid));
         check($sformatf("v%0d_count", i), 64'(cnt_a), 64'(tbl[i].e_cnt));
         check($sformatf("v%0d_instr_pc", i), oip_a, tbl[i].e_ip);
         step();
      end

      // Wavefront flush sequence on DUT B: wfids 3,7,3 queued, then flush wfid 3
      rst_b = 1'b0;
      step();
      for (int k = 0; k < 3; k++) begin
         iv_b = 1'b1; iw_b = (k == 1) ? 6'd7 : 6'd3;
         ipc_b = 32'(k); iins_b = 32'(k + 16);
         step();
      end
      iv_b = 1'b0;
      check("flush_setup_count", 64'(cnt_b), 64'd3);
      fv_b = 1'b1; fw_b = 6'd3;
      step();
      fv_b = 1'b0; ordy_b = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c == 3) check("flush_drain_count", 64'(cnt_b), 64'd0);
         if (ov_b === 1'b1) seen.push_back(ow_b);
         step();
      end
      if (FLUSH_EN) exp_seen = '{6'd7};
      else          exp_seen = '{6'd3, 6'd7, 6'd3};
      check("flush_out_len", 64'(seen.size()), 64'(exp_seen.size()));
      for (int j = 0; j < exp_seen.size(); j++) begin
         if (j < seen.size()) check($sformatf("flush_out_%0d", j), 64'(seen[j]), 64'(exp_seen[j]));
      end

      // Random traffic on DUT B against a queue model
      m_rdy = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         bit          pop, acc;
         logic        e_ov, e_first;
         logic [5:0]  e_wfid;
         logic [63:0] e_ip;
         rst_b  = ($urandom_range(0, 99) == 0);
         iv_b   = ($urandom_range(0, 2) != 0);
         if_b   = 1'($urandom_range(0, 1));
         iw_b   = 6'($urandom_range(0, 3));
         ipc_b  = $urandom;
         iins_b = $urandom;
         ordy_b = 1'($urandom_range(0, 1));
         fv_b   = ($urandom_range(0, 7) == 0);
         fw_b   = 6'($urandom_range(0, 3));

         e_ov = (mq.size() > 0) && mq[0].live;
         e_first = e_ov ? mq[0].first : 1'b0;
         e_wfid  = e_ov ? mq[0].wfid : 6'd0;
         e_ip    = e_ov ? {mq[0].instr, mq[0].pc} : 64'd0;
         check($sformatf("rnd%0d_ctl", n), 64'({rdy_b, ov_b, of_b, ow_b, cnt_b}),
               64'({m_rdy, e_ov, e_first, e_wfid, 3'(mq.size())}));
         check($sformatf("rnd%0d_instr_pc", n), oip_b, e_ip);

         if (rst_b) begin
            mq.delete();
            m_rdy = 1'b0;
         end else begin
            pop = (mq.size() > 0) && (!mq[0].live || ordy_b);
            acc = iv_b && m_rdy;
            if (FLUSH_EN && fv_b) begin
               foreach (mq[j]) if (mq[j].wfid == fw_b) mq[j].live = 1'b0;
            end
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back('{if_b, iw_b, ipc_b, iins_b, !(FLUSH_EN && fv_b && (iw_b == fw_b))});
            m_rdy = (mq.size() < 4);
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
